// File: rtl/comm_cmd_sched.sv
// Command scheduler in front of CommMaster: queues requester commands, injects
// periodic battery polls, runs send/ack/retry per transaction and reports outcome.
module comm_cmd_sched #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned TIMEOUT     = 200000,
   parameter int unsigned MAX_RETRY   = 2,
   parameter int unsigned BATT_PERIOD = 5000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_vld,
   input  logic [7:0]  req_cmd,
   input  logic [15:0] req_data,
   output logic        req_rdy,
   input  logic        batt_en,
   output logic        snd_cmd,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   input  logic        frm_snt,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_frm_snt_out,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  err_cmd,
   output logic [7:0]  batt_lvl,
   output logic        batt_vld
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned BW = $clog2(BATT_PERIOD + 1);
   localparam int unsigned RW = $clog2(MAX_RETRY + 2);
   localparam logic [7:0]  OP_BATT = 8'h01;
   localparam logic [7:0]  RSP_ACK = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_WAIT_SNT, S_WAIT_RESP, S_CHECK
   } state_t;

   state_t         r_state, w_state_nxt;
   logic [7:0]     r_mem_cmd  [DEPTH];
   logic [15:0]    r_mem_data [DEPTH];
   logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]  r_count, w_count_nxt;
   logic [TW-1:0]  r_to;
   logic [BW-1:0]  r_tmr;
   logic [RW-1:0]  r_retry;
   logic           r_batt_pend, r_src_batt;
   logic [7:0]     r_cmd, r_err_cmd, r_batt_lvl;
   logic [15:0]    r_data;
   logic           r_snd, r_clr, r_done, r_err, r_bv, r_busy, r_rdy;
   logic           w_push, w_pop, w_start, w_to_hit, w_tmr_wrap, w_batt_launch;
   logic           w_rsp_ok, w_fail;
   logic           w_snd_nxt, w_clr_nxt, w_done_nxt, w_err_nxt, w_bv_nxt, w_busy_nxt;

   assign w_push        = req_vld && (r_count < CW'(DEPTH));
   assign w_pop         = (r_state == S_CHECK) && (r_done || r_err) && !r_src_batt;
   assign w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
   assign w_start       = r_batt_pend || (r_count != '0);
   assign w_to_hit      = (r_to == TW'(TIMEOUT - 1));
   assign w_tmr_wrap    = (r_tmr == BW'(BATT_PERIOD - 1));
   assign w_batt_launch = (r_state == S_IDLE) && r_batt_pend;
   assign w_rsp_ok      = (r_cmd == OP_BATT) || (rx_data == RSP_ACK);

   // Command FIFO; a push while full is dropped regardless of a same-cycle pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_cmd[r_wr_ptr]  <= req_cmd;
         r_mem_data[r_wr_ptr] <= req_data;
      end
   end

   // Battery poll timer; a due poll is remembered until launched and never stacks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmr       <= '0;
         r_batt_pend <= 1'b0;
      end else begin
         if (!batt_en || w_tmr_wrap) r_tmr <= '0;
         else                        r_tmr <= r_tmr + BW'(1);
         if (batt_en && w_tmr_wrap)  r_batt_pend <= 1'b1;
         else if (w_batt_launch)     r_batt_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Timeouts and all response outcomes funnel through CHECK so retries see one clr pulse
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:      if (w_start) w_state_nxt = S_SEND;
         S_SEND:      w_state_nxt = S_WAIT_SNT;
         S_WAIT_SNT:  if (frm_snt) w_state_nxt = S_WAIT_RESP;
                      else if (w_to_hit) w_state_nxt = S_CHECK;
         S_WAIT_RESP: if (rx_rdy || w_to_hit) w_state_nxt = S_CHECK;
         S_CHECK:     w_state_nxt = (r_done || r_err) ? S_IDLE : S_SEND;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_done_nxt = 1'b0;
      w_fail     = 1'b0;
      w_snd_nxt  = (w_state_nxt == S_SEND);
      w_clr_nxt  = (w_state_nxt == S_CHECK);
      w_busy_nxt = (w_state_nxt != S_IDLE);
      case (r_state)
         S_WAIT_SNT:  w_fail = !frm_snt && w_to_hit;
         S_WAIT_RESP: begin
            if (rx_rdy) begin
               w_done_nxt = w_rsp_ok;
               w_fail     = !w_rsp_ok;
            end else begin
               w_fail = w_to_hit;
            end
         end
         default: ;
      endcase
      w_err_nxt = w_fail && (r_retry == RW'(MAX_RETRY));
      w_bv_nxt  = w_done_nxt && (r_cmd == OP_BATT);
   end

   // Transaction datapath: selected command, attempt count, timeout counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to       <= '0;
         r_retry    <= '0;
         r_cmd      <= '0;
         r_data     <= '0;
         r_src_batt <= 1'b0;
         r_err_cmd  <= '0;
         r_batt_lvl <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_retry <= '0;
               if (w_start) begin
                  r_src_batt <= r_batt_pend;
                  r_cmd      <= r_batt_pend ? OP_BATT : r_mem_cmd[r_rd_ptr];
                  r_data     <= r_batt_pend ? 16'h0000 : r_mem_data[r_rd_ptr];
               end
            end
            S_SEND:                  r_to <= '0;
            S_WAIT_SNT, S_WAIT_RESP: r_to <= r_to + TW'(1);
            S_CHECK: if (w_state_nxt == S_SEND) r_retry <= r_retry + RW'(1);
            default: ;
         endcase
         if (w_err_nxt) r_err_cmd  <= r_cmd;
         if (w_bv_nxt)  r_batt_lvl <= rx_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_snd  <= 1'b0;
         r_clr  <= 1'b0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_bv   <= 1'b0;
         r_busy <= 1'b0;
         r_rdy  <= 1'b1;
      end else begin
         r_snd  <= w_snd_nxt;
         r_clr  <= w_clr_nxt;
         r_done <= w_done_nxt;
         r_err  <= w_err_nxt;
         r_bv   <= w_bv_nxt;
         r_busy <= w_busy_nxt;
         r_rdy  <= (w_count_nxt < CW'(DEPTH));
      end
   end

   assign req_rdy         = r_rdy;
   assign snd_cmd         = r_snd;
   assign cmd             = r_cmd;
   assign data            = r_data;
   assign clr_frm_snt_out = r_clr;
   assign busy            = r_busy;
   assign done            = r_done;
   assign err             = r_err;
   assign err_cmd         = r_err_cmd;
   assign batt_lvl        = r_batt_lvl;
   assign batt_vld        = r_bv;

endmodule

// File: tb/tb_comm_cmd_sched.sv
// Directed bench for comm_cmd_sched with a small CommMaster responder model.
module tb_comm_cmd_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_vld = 1'b0;
   logic [7:0]  req_cmd = '0;
   logic [15:0] req_data = '0;
   logic        req_rdy;
   logic        batt_en = 1'b0;
   logic        snd_cmd;
   logic [7:0]  cmd;
   logic [15:0] data;
   logic        frm_snt, rx_rdy;
   logic [7:0]  rx_data;
   logic        clr_frm_snt_out, busy, done, err, batt_vld;
   logic [7:0]  err_cmd, batt_lvl;

   comm_cmd_sched #(.DEPTH(4), .TIMEOUT(100), .MAX_RETRY(2), .BATT_PERIOD(1000)) dut (
      .clk(clk), .rst(rst), .req_vld(req_vld), .req_cmd(req_cmd), .req_data(req_data),
      .req_rdy(req_rdy), .batt_en(batt_en), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
      .frm_snt(frm_snt), .rx_rdy(rx_rdy), .rx_data(rx_data),
      .clr_frm_snt_out(clr_frm_snt_out), .busy(busy), .done(done), .err(err),
      .err_cmd(err_cmd), .batt_lvl(batt_lvl), .batt_vld(batt_vld));

   always #5 clk = ~clk;

   int n_vec = 0, n_bad = 0;
   int cyc = 0, n_snd = 0, n_done = 0, n_err = 0, n_clr = 0, n_bv = 0;
   logic [7:0]  log_cmd  [64];
   logic [15:0] log_data [64];
   int          log_cyc  [64];
   logic [7:0]  rsp_arr  [3];
   int          rsp_base = 0;
   int          resp_dly = 5;
   logic        mute = 1'b0;

   // Responder: raises frm_snt 3 cycles after snd_cmd, answers resp_dly cycles later
   initial begin : model
      int phase, tmr, idx;
      phase = 0; tmr = 0;
      frm_snt = 1'b0; rx_rdy = 1'b0; rx_data = '0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         rx_rdy = 1'b0;
         if (done)     n_done++;
         if (err)      n_err++;
         if (batt_vld) n_bv++;
         if (clr_frm_snt_out) begin n_clr++; frm_snt = 1'b0; end
         if (rst) begin
            phase = 0; frm_snt = 1'b0;
         end else if (snd_cmd) begin
            log_cmd[n_snd % 64] = cmd; log_data[n_snd % 64] = data; log_cyc[n_snd % 64] = cyc;
            n_snd++; phase = 1; tmr = 3;
         end else if (phase == 1) begin
            tmr--;
            if (tmr == 0) begin frm_snt = 1'b1; phase = 2; tmr = resp_dly; end
         end else if (phase == 2) begin
            tmr--;
            if (tmr == 0) begin
               if (!mute) begin
                  idx = n_snd - 1 - rsp_base;
                  rx_rdy  = 1'b1;
                  rx_data = (idx >= 0 && idx < 3) ? rsp_arr[idx] : 8'hA5;
               end
               phase = 0;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic push(input logic [7:0] c, input logic [15:0] d);
      req_vld = 1'b1; req_cmd = c; req_data = d;
      tick();
      req_vld = 1'b0;
   endtask

   task automatic wait_txn(input string nm);
      int k;
      logic seen;
      k = 0;
      while (!busy && k < 10) begin tick(); k++; end
      seen = busy;
      k = 0;
      while (busy && k < 2000) begin tick(); k++; end
      chk({nm, "_idle"}, 32'(seen && !busy), 32'd1);
   endtask

   task automatic wait_snd(input string nm, input int n);
      int k;
      k = 0;
      while (n_snd < n && k < 3000) begin tick(); k++; end
      chk({nm, "_sndwait"}, 32'(n_snd >= n), 32'd1);
   endtask

   typedef struct {
      logic [7:0]  c;
      logic [15:0] d;
      logic [7:0]  r0, r1, r2;
      logic        mute;
      int          e_snd, e_done, e_err, e_clr, e_bv;
      logic [7:0]  e_err_cmd, e_batt;
   } vec_t;

   initial begin : main
      vec_t        vt [5];
      int          s_snd, s_done, s_err, s_clr, s_bv, k;
      logic [7:0]  bc [5];
      logic [15:0] bd [5];
      logic [7:0]  pc [4];
      logic [15:0] pd [4];

      vt[0] = '{8'h02, 16'h0001, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1, 1, 0, 1, 0, 8'h00, 8'h00};
      vt[1] = '{8'h05, 16'h0003, 8'h5A, 8'h5A, 8'hA5, 1'b0, 3, 1, 0, 3, 0, 8'h00, 8'h00};
      vt[2] = '{8'h05, 16'h0004, 8'h5A, 8'h5A, 8'h5A, 1'b0, 3, 0, 1, 3, 0, 8'h05, 8'h00};
      vt[3] = '{8'h03, 16'h1234, 8'hA5, 8'hA5, 8'hA5, 1'b1, 3, 0, 1, 3, 0, 8'h03, 8'h00};
      vt[4] = '{8'h01, 16'h0000, 8'h42, 8'hA5, 8'hA5, 1'b0, 1, 1, 0, 1, 1, 8'h00, 8'h42};
      bc = '{8'h02, 8'h03, 8'h04, 8'h06, 8'h07};
      bd = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050};
      rsp_arr = '{8'hA5, 8'hA5, 8'hA5};

      // Reset state
      repeat (3) tick();
      chk("rst_pulses", 32'({snd_cmd, clr_frm_snt_out, done, err, batt_vld, busy}), 32'd0);
      chk("rst_cmd_data", {8'h00, cmd, data}, 32'd0);
      chk("rst_errcmd_batt", 32'({err_cmd, batt_lvl}), 32'd0);
      rst = 1'b0;
      tick();
      chk("rst_req_rdy", 32'(req_rdy), 32'd1);

      // Push-to-snd_cmd latency of two cycles
      push(8'h08, 16'h00AB);
      chk("lat_snd_early", 32'(snd_cmd), 32'd0);
      tick();
      chk("lat_snd", 32'(snd_cmd), 32'd1);
      chk("lat_cmd_data", {8'h00, cmd, data}, {8'h00, 8'h08, 16'h00AB});
      wait_txn("lat");
      repeat (3) tick();

      // Single-transaction vectors: ACK, NAK-then-ACK, all-NAK, timeout, battery opcode
      for (int i = 0; i < 5; i++) begin
         s_snd = n_snd; s_done = n_done; s_err = n_err; s_clr = n_clr; s_bv = n_bv;
         rsp_base = n_snd;
         rsp_arr = '{vt[i].r0, vt[i].r1, vt[i].r2};
         mute = vt[i].mute;
         push(vt[i].c, vt[i].d);
         wait_txn($sformatf("v%0d", i));
         repeat (10) tick();
         chk($sformatf("v%0d_snd", i),  n_snd - s_snd,   vt[i].e_snd);
         chk($sformatf("v%0d_done", i), n_done - s_done, vt[i].e_done);
         chk($sformatf("v%0d_err", i),  n_err - s_err,   vt[i].e_err);
         chk($sformatf("v%0d_clr", i),  n_clr - s_clr,   vt[i].e_clr);
         chk($sformatf("v%0d_bv", i),   n_bv - s_bv,     vt[i].e_bv);
         chk($sformatf("v%0d_issued", i), {8'h00, log_cmd[s_snd % 64], log_data[s_snd % 64]},
             {8'h00, vt[i].c, vt[i].d});
         chk($sformatf("v%0d_rdy_busy", i), 32'({req_rdy, busy}), 32'b10);
         if (vt[i].e_err > 0) chk($sformatf("v%0d_err_cmd", i), 32'(err_cmd), 32'(vt[i].e_err_cmd));
         if (vt[i].e_bv > 0)  chk($sformatf("v%0d_batt", i), 32'(batt_lvl), 32'(vt[i].e_batt));
         if (vt[i].mute)
            for (int j = 1; j < 3; j++)
               chk($sformatf("v%0d_retry_gap%0d", i, j),
                   log_cyc[(s_snd + j) % 64] - log_cyc[(s_snd + j - 1) % 64], 32'd102);
      end
      mute = 1'b0;

      // Five back-to-back pushes into a 4-deep FIFO: fifth dropped, order preserved
      s_snd = n_snd; rsp_base = n_snd; rsp_arr = '{8'hA5, 8'hA5, 8'hA5};
      for (int j = 0; j < 5; j++) begin
         req_vld = 1'b1; req_cmd = bc[j]; req_data = bd[j];
         tick();
         chk($sformatf("full_rdy%0d", j), 32'(req_rdy), (j < 3) ? 32'd1 : 32'd0);
      end
      req_vld = 1'b0;
      wait_snd("full", s_snd + 4);
      wait_txn("full");
      repeat (20) tick();
      chk("full_snd_count", n_snd - s_snd, 32'd4);
      for (int j = 0; j < 4; j++)
         chk($sformatf("full_order%0d", j), {8'h00, log_cmd[(s_snd + j) % 64], log_data[(s_snd + j) % 64]},
             {8'h00, bc[j], bd[j]});

      // Battery poll comes due while the FIFO still holds two commands
      pc = '{8'h02, 8'h01, 8'h03, 8'h04};
      pd = '{16'h0100, 16'h0000, 16'h0200, 16'h0300};
      s_snd = n_snd; s_bv = n_bv; rsp_base = n_snd; rsp_arr = '{8'hA5, 8'hC3, 8'hA5};
      resp_dly = 60;
      batt_en = 1'b1;
      repeat (960) tick();
      push(8'h02, 16'h0100);
      push(8'h03, 16'h0200);
      push(8'h04, 16'h0300);
      wait_snd("poll_a", s_snd + 2);
      batt_en = 1'b0;
      wait_snd("poll_b", s_snd + 4);
      wait_txn("poll");
      repeat (5) tick();
      chk("poll_snd_count", n_snd - s_snd, 32'd4);
      for (int j = 0; j < 4; j++)
         chk($sformatf("poll_order%0d", j), {8'h00, log_cmd[(s_snd + j) % 64], log_data[(s_snd + j) % 64]},
             {8'h00, pc[j], pd[j]});
      chk("poll_batt_lvl", 32'(batt_lvl), 32'h0000_00C3);
      chk("poll_batt_vld", n_bv - s_bv, 32'd1);

      // Reset mid-WAIT_RESP with two entries queued
      s_snd = n_snd; rsp_base = n_snd; resp_dly = 50;
      push(8'h05, 16'h0001);
      push(8'h06, 16'h0002);
      push(8'h07, 16'h0003);
      k = 0;
      while (!frm_snt && k < 50) begin tick(); k++; end
      tick(); tick();
      chk("rstmid_busy_before", 32'({busy, frm_snt}), 32'b11);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_pulses", 32'({snd_cmd, clr_frm_snt_out, done, err, batt_vld, busy}), 32'd0);
      chk("rstmid_cmd_data", {8'h00, cmd, data}, 32'd0);
      chk("rstmid_errcmd_batt", 32'({err_cmd, batt_lvl}), 32'd0);
      chk("rstmid_rdy", 32'(req_rdy), 32'd1);
      tick(); tick();
      rst = 1'b0;
      resp_dly = 5;
      repeat (20) tick();
      chk("rstmid_no_snd", n_snd - s_snd, 32'd1);
      chk("rstmid_idle", 32'(busy), 32'd0);
      rsp_base = n_snd;
      push(8'h02, 16'h0009);
      wait_txn("rstmid_new");
      chk("rstmid_new_snd", n_snd - s_snd, 32'd2);
      chk("rstmid_new_cmd", {8'h00, log_cmd[(s_snd + 1) % 64], log_data[(s_snd + 1) % 64]},
          {8'h00, 8'h02, 16'h0009});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end
endmodule
